mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port synchronous memory.
// Data has priority, except fetch wins once it has waited through STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_LIMIT = 255,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StAck} state_e;
  typedef enum logic {OwnFetch, OwnData} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [1:0]  starve_q, starve_d;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [63:0] wdata_q;
  logic [63:0] f_rdata_q, d_rdata_q;
  logic        f_err_q, d_err_q;

  logic        grant;
  logic        pick_fetch;
  logic [63:0] req_addr;
  logic        addr_bad;

  always_comb begin
    grant      = f_req || d_req;
    pick_fetch = f_req && (!d_req || (starve_q == 2'(STARVE_MAX)));
    req_addr   = pick_fetch ? f_addr : d_addr;
    addr_bad   = req_addr > 64'(ADDR_LIMIT);
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = pick_fetch ? OwnFetch : OwnData;
          state_d = addr_bad ? StAck : StIssue;
          // Only data grants made while fetch is waiting count toward starvation.
          if (pick_fetch) begin
            starve_d = '0;
          end else if (f_req && (starve_q != 2'(STARVE_MAX))) begin
            starve_d = starve_q + 2'd1;
          end
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StAck;
      StAck:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    f_ack     = (state_q == StAck) && (owner_q == OwnFetch);
    d_ack     = (state_q == StAck) && (owner_q == OwnData);
    f_rdata   = f_rdata_q;
    f_err     = f_err_q;
    d_rdata   = d_rdata_q;
    d_err     = d_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= OwnData;
      starve_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      f_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if ((state_q == StIdle) && grant) begin
        we_q    <= !pick_fetch && d_we;
        addr_q  <= req_addr[7:0];
        wdata_q <= pick_fetch ? '0 : d_wdata;
        // Out-of-range accesses skip the memory and complete straight from IDLE.
        if (addr_bad) begin
          if (pick_fetch) begin
            f_rdata_q <= '0;
            f_err_q   <= 1'b1;
          end else begin
            d_rdata_q <= '0;
            d_err_q   <= 1'b1;
          end
        end
      end
      if (state_q == StCapture) begin
        if (owner_q == OwnFetch) begin
          f_rdata_q <= we_q ? '0 : mem_rdata;
          f_err_q   <= 1'b0;
        end else begin
          d_rdata_q <= we_q ? '0 : mem_rdata;
          d_err_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1-cycle memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_ack;
  logic [63:0] f_rdata;
  logic        f_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter #(.ADDR_LIMIT(255), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [256];
  int cyc = 0;
  int n_en = 0, n_we = 0, n_dack = 0;
  bit dual = 1'b0;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en) n_en++;
    if (mem_we) n_we++;
    if (d_ack) n_dack++;
    if (f_ack && d_ack) dual = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the cycle of the requested ack, or -1 if it never came.
  task automatic wait_ack(input bit is_data, output int at);
    at = -1;
    for (int i = 0; i < 20 && at < 0; i++) begin
      @(negedge clk);
      if (is_data ? d_ack : f_ack) at = cyc;
    end
  endtask

  task automatic access(input bit is_data, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat);
    int start, at;
    @(posedge clk); #1;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    start = cyc;
    wait_ack(is_data, at);
    rdata = is_data ? d_rdata : f_rdata;
    err   = is_data ? d_err : f_err;
    lat   = (at < 0) ? -1 : at - start + 1;
    @(posedge clk); #1;
    if (is_data) d_req = 1'b0; else f_req = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat, en0, we0, dack0, a1, a2, k;
  bit          order [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 64'hAB;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_f_ack", f_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_f_rdata", f_rdata, 0);
    #1 rst_n = 1'b1;

    // Data write then read of address 4
    en0 = n_en; we0 = n_we;
    access(1, 1, 64'd4, 64'h1, rd, er, lat);
    check("wr_lat", 64'(lat), 4);
    check("wr_rdata", rd, 0);
    check("wr_mem_en", 64'(n_en - en0), 1);
    check("wr_mem_we", 64'(n_we - we0), 1);
    en0 = n_en; we0 = n_we;
    access(1, 0, 64'd4, 64'h0, rd, er, lat);
    check("rd_lat", 64'(lat), 4);
    check("rd_rdata", rd, 64'h1);
    check("rd_err", er, 0);
    check("rd_mem_en", 64'(n_en - en0), 1);
    check("rd_mem_we", 64'(n_we - we0), 0);

    // Out-of-range data read
    en0 = n_en;
    access(1, 0, 64'd256, 64'h0, rd, er, lat);
    check("err_lat", 64'(lat), 2);
    check("err_flag", er, 1);
    check("err_rdata", rd, 0);
    check("err_mem_en", 64'(n_en - en0), 0);
    check("err_rdata_hold", d_rdata, 0);

    // Fetch read
    we0 = n_we;
    access(0, 0, 64'h10, 64'h0, rd, er, lat);
    check("f_lat", 64'(lat), 4);
    check("f_rdata", rd, 64'hAB);
    check("f_err", er, 0);
    check("f_mem_we", 64'(n_we - we0), 0);

    // Reset during CAPTURE of a data read
    access(1, 0, 64'd4, 64'h0, rd, er, lat);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd4; k = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("cap_busy", busy, 1);
    dack0 = n_dack;
    rst_n = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_d_ack", d_ack, 0);
    check("midrst_d_rdata", d_rdata, 0);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("midrst_no_ack", 64'(n_dack - dack0), 0);
    access(0, 0, 64'h10, 64'h0, rd, er, lat);
    check("post_f_lat", 64'(lat), 4);
    check("post_f_rdata", rd, 64'hAB);

    // Back-to-back data writes
    en0 = n_en;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd0; d_wdata = 64'h1111;
    wait_ack(1, a1);
    @(posedge clk); #1;
    d_addr = 64'd1; d_wdata = 64'h2222;
    wait_ack(1, a2);
    @(posedge clk); #1;
    d_req = 1'b0;
    check("b2b_first_ack", 64'(a1 >= 0), 1);
    check("b2b_spacing", 64'(a2 - a1), 4);
    check("b2b_mem_en", 64'(n_en - en0), 2);
    check("b2b_mem0", mem[0], 64'h1111);
    check("b2b_mem1", mem[1], 64'h2222);

    // Both requesters held high: starvation limit forces every fourth grant to fetch
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 64'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd4;
    for (int i = 0; i < 100 && order.size() < 8; i++) begin
      @(negedge clk);
      if (d_ack) order.push_back(1'b1);
      else if (f_ack) order.push_back(1'b0);
    end
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0;
    check("order_len", 64'(order.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < order.size()) check($sformatf("order_%0d", i), order[i], (i % 4 == 3) ? 0 : 1);
    end
    repeat (3) @(posedge clk);
    check("no_dual_ack", dual, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
